// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP controller with IDCODE, USER (read/write) and BYPASS data registers.
// Define JTAG_USERCODE_EN to add instruction 3 selecting a 32-bit USERCODE DR loaded with USERCODE_VAL.
module jtag_tap_param #(
    parameter int          IR_LEN     = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int          USER_W     = 8
`ifdef JTAG_USERCODE_EN
    ,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_0000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_oe,
    input  logic [USER_W-1:0] user_in,
    output logic [USER_W-1:0] user_out,
    output logic              user_upd,
    output logic [3:0]        tap_state,
    output logic [IR_LEN-1:0] ir_out
);

    typedef enum logic [3:0] {
        TLR      = 4'h0, RTI      = 4'h1, SEL_DR   = 4'h2, CAP_DR = 4'h3,
        SH_DR    = 4'h4, EX1_DR   = 4'h5, PAUSE_DR = 4'h6, EX2_DR = 4'h7,
        UPD_DR   = 4'h8, SEL_IR   = 4'h9, CAP_IR   = 4'hA, SH_IR  = 4'hB,
        EX1_IR   = 4'hC, PAUSE_IR = 4'hD, EX2_IR   = 4'hE, UPD_IR = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS   = 2'd0,
        DR_IDCODE   = 2'd1,
        DR_USER     = 2'd2,
        DR_USERCODE = 2'd3
    } dr_sel_e;

    localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(2'b01);
    localparam logic [IR_LEN-1:0] IR_USER    = IR_LEN'(2'b10);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);
`ifdef JTAG_USERCODE_EN
    localparam logic [IR_LEN-1:0] IR_USERCODE = IR_LEN'(2'b11);
`endif

    tap_state_e        state_q, state_d;
    logic [IR_LEN-1:0] ir_q, ir_d, ir_upd_s;
    logic [IR_LEN-1:0] ir_sr_q, ir_sr_d;
    logic [31:0]       idcode_sr_q, idcode_sr_d;
    logic [USER_W-1:0] user_sr_q, user_sr_d;
    logic              bypass_q, bypass_d;
`ifdef JTAG_USERCODE_EN
    logic [31:0]       usercode_sr_q, usercode_sr_d;
`endif
    logic              tdo_q, tdo_d;
    logic              tdo_oe_q, tdo_oe_d;
    logic [USER_W-1:0] user_out_q, user_out_d;
    logic              user_upd_q, user_upd_d;
    dr_sel_e           dr_sel_s;

    // TAP state transition table
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Instruction decode; unknown opcodes fall back to BYPASS
    always_comb begin
        dr_sel_s = DR_BYPASS;
        case (ir_q)
            IR_IDCODE:   dr_sel_s = DR_IDCODE;
            IR_USER:     dr_sel_s = DR_USER;
`ifdef JTAG_USERCODE_EN
            IR_USERCODE: dr_sel_s = DR_USERCODE;
`endif
            default:     dr_sel_s = DR_BYPASS;
        endcase
    end

    // Capture/shift/update datapath for IR and the selected DR
    always_comb begin
        ir_sr_d     = ir_sr_q;
        ir_upd_s    = ir_q;
        idcode_sr_d = idcode_sr_q;
        user_sr_d   = user_sr_q;
        bypass_d    = bypass_q;
`ifdef JTAG_USERCODE_EN
        usercode_sr_d = usercode_sr_q;
`endif
        tdo_d       = tdo_q;
        user_out_d  = user_out_q;
        user_upd_d  = 1'b0;
        case (state_q)
            CAP_IR: ir_sr_d = IR_CAPTURE;
            SH_IR: begin
                tdo_d               = ir_sr_q[0];
                ir_sr_d             = ir_sr_q >> 1'b1;
                ir_sr_d[IR_LEN-1]   = tdi;
            end
            UPD_IR: ir_upd_s = ir_sr_q;
            CAP_DR: begin
                case (dr_sel_s)
                    DR_IDCODE:   idcode_sr_d   = IDCODE_VAL;
                    DR_USER:     user_sr_d     = user_in;
`ifdef JTAG_USERCODE_EN
                    DR_USERCODE: usercode_sr_d = USERCODE_VAL;
`endif
                    default:     bypass_d      = 1'b0;
                endcase
            end
            SH_DR: begin
                case (dr_sel_s)
                    DR_IDCODE: begin
                        tdo_d       = idcode_sr_q[0];
                        idcode_sr_d = {tdi, idcode_sr_q[31:1]};
                    end
                    DR_USER: begin
                        tdo_d                = user_sr_q[0];
                        user_sr_d            = user_sr_q >> 1'b1;
                        user_sr_d[USER_W-1]  = tdi;
                    end
`ifdef JTAG_USERCODE_EN
                    DR_USERCODE: begin
                        tdo_d         = usercode_sr_q[0];
                        usercode_sr_d = {tdi, usercode_sr_q[31:1]};
                    end
`endif
                    default: begin
                        tdo_d    = bypass_q;
                        bypass_d = tdi;
                    end
                endcase
            end
            UPD_DR: begin
                if (dr_sel_s == DR_USER) begin
                    user_out_d = user_sr_q;
                    user_upd_d = 1'b1;
                end else begin
                    user_out_d = user_out_q;
                end
            end
            default: begin
            end
        endcase
        // Any path into Test-Logic-Reset restores the IDCODE instruction
        ir_d     = (state_d == TLR) ? IR_IDCODE : ir_upd_s;
        tdo_oe_d = (state_d == SH_IR) || (state_d == SH_DR);
    end

    // All TAP state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TLR;
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            idcode_sr_q <= 32'h0000_0000;
            user_sr_q   <= '0;
            bypass_q    <= 1'b0;
`ifdef JTAG_USERCODE_EN
            usercode_sr_q <= 32'h0000_0000;
`endif
            tdo_q       <= 1'b0;
            tdo_oe_q    <= 1'b0;
            user_out_q  <= '0;
            user_upd_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            idcode_sr_q <= idcode_sr_d;
            user_sr_q   <= user_sr_d;
            bypass_q    <= bypass_d;
`ifdef JTAG_USERCODE_EN
            usercode_sr_q <= usercode_sr_d;
`endif
            tdo_q       <= tdo_d;
            tdo_oe_q    <= tdo_oe_d;
            user_out_q  <= user_out_d;
            user_upd_q  <= user_upd_d;
        end
    end

    assign tdo       = tdo_q;
    assign tdo_oe    = tdo_oe_q;
    assign user_out  = user_out_q;
    assign user_upd  = user_upd_q;
    assign tap_state = state_q;
    assign ir_out    = ir_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: a table-driven TAP model checked every cycle plus literal expectations.
module tb_jtag_tap_param;
    localparam int IR_LEN = 4;
    localparam int USER_W = 8;

    logic              clk = 1'b0;
    logic              rst_n, tms, tdi, tdo, tdo_oe, user_upd;
    logic [USER_W-1:0] user_in, user_out;
    logic [3:0]        tap_state;
    logic [IR_LEN-1:0] ir_out;

    always #5 clk = ~clk;

    jtag_tap_param #(.IR_LEN(IR_LEN), .IDCODE_VAL(32'h1000_0001), .USER_W(USER_W)) dut (
        .clk(clk), .rst_n(rst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
        .user_in(user_in), .user_out(user_out), .user_upd(user_upd),
        .tap_state(tap_state), .ir_out(ir_out)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: state via next-state tables, DRs as plain words indexed 0=bypass, 1=idcode, 2=user
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int m_len [3] = '{1, 32, USER_W};
    int          m_state;
    logic [3:0]  m_ir, m_irsr;
    logic [31:0] m_dr [3];
    logic        m_tdo, m_oe, m_upd;
    logic [7:0]  m_uout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int sel_of(input logic [3:0] ir);
        if (ir == 4'd1) return 1;
        if (ir == 4'd2) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ir = 4'd1; m_irsr = 4'd0;
        for (int i = 0; i < 3; i++) m_dr[i] = 32'd0;
        m_tdo = 1'b0; m_oe = 1'b0; m_upd = 1'b0; m_uout = 8'd0;
    endtask

    task automatic model_step(input logic t, input logic d);
        int s = sel_of(m_ir);
        int old = m_state;
        m_upd = 1'b0;
        if (old == 10) m_irsr = 4'b0001;
        if (old == 11) begin m_tdo = m_irsr[0]; m_irsr = {d, m_irsr[3:1]}; end
        if (old == 15) m_ir = m_irsr;
        if (old == 3) m_dr[s] = (s == 1) ? 32'h1000_0001 : (s == 2) ? {24'd0, user_in} : 32'd0;
        if (old == 4) begin
            m_tdo = m_dr[s][0];
            m_dr[s] = m_dr[s] >> 1;
            m_dr[s][m_len[s]-1] = d;
        end
        if (old == 8 && s == 2) begin m_uout = m_dr[2][7:0]; m_upd = 1'b1; end
        m_state = t ? nxt1[old] : nxt0[old];
        if (m_state == 0) m_ir = 4'd1;
        m_oe = (m_state == 4) || (m_state == 11);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_state", {28'd0, tap_state}, m_state);
            check("cyc_ir", {28'd0, ir_out}, {28'd0, m_ir});
            check("cyc_tdo", {31'd0, tdo}, {31'd0, m_tdo});
            check("cyc_oe", {31'd0, tdo_oe}, {31'd0, m_oe});
            check("cyc_uout", {24'd0, user_out}, {24'd0, m_uout});
            check("cyc_upd", {31'd0, user_upd}, {31'd0, m_upd});
        end
    end

    task automatic tick(input logic t, input logic d);
        tms = t; tdi = d;
        @(posedge clk);
        model_step(t, d);
        @(negedge clk);
    endtask

    task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = 32'd0;
        for (int i = 0; i < n; i++) begin
            tick((i == n - 1), din[i]);
            dout[i] = tdo;
        end
    endtask

    task automatic goto_shdr(); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); endtask
    task automatic goto_shir(); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); endtask
    task automatic exit_upd();  tick(1'b1, 1'b0); tick(1'b0, 1'b0); endtask

    task automatic load_ir(input logic [3:0] v);
        logic [31:0] dummy;
        goto_shir();
        shift_bits(4, {28'd0, v}, dummy);
        exit_upd();
    endtask

    logic [31:0] dout;

    initial begin
        rst_n = 1'b0; tms = 1'b1; tdi = 1'b0; user_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_state", {28'd0, tap_state}, 32'h0);
        check("rst_ir", {28'd0, ir_out}, 32'h1);
        check("rst_tdo", {30'd0, tdo, tdo_oe}, 32'h0);
        check("rst_uout", {23'd0, user_out, user_upd}, 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        repeat (5) tick(1'b1, 1'b0);
        check("tlr_state", {28'd0, tap_state}, 32'h0);
        check("tlr_ir", {28'd0, ir_out}, 32'h1);
        check("tlr_oe", {31'd0, tdo_oe}, 32'h0);

        // IDCODE readout: TLR -> RTI -> SelDR -> CapDR -> ShDR
        tick(1'b0, 1'b0); goto_shdr();
        check("shdr_oe", {31'd0, tdo_oe}, 32'h1);
        shift_bits(32, 32'h0, dout);
        check("idcode", dout, 32'h1000_0001);

        // Ex1DR -> UpdDR -> SelDR -> SelIR -> CapIR -> ShIR, load BYPASS
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        shift_bits(4, 32'hF, dout);
        check("ir_capture", dout, 32'h1);
        exit_upd();
        check("ir_bypass", {28'd0, ir_out}, 32'hF);
        goto_shdr();
        shift_bits(4, 32'b1101, dout);
        check("bypass_delay", dout, 32'b1010);
        exit_upd();

        // USER DR: capture A5, shift in 3C, update
        load_ir(4'b0010);
        check("ir_user", {28'd0, ir_out}, 32'h2);
        user_in = 8'hA5;
        goto_shdr();
        shift_bits(8, 32'h3C, dout);
        check("user_capture", dout, 32'hA5);
        tick(1'b1, 1'b0);
        check("upd_pre", {31'd0, user_upd}, 32'h0);
        tick(1'b0, 1'b0);
        check("user_out", {24'd0, user_out}, 32'h3C);
        check("upd_pulse", {31'd0, user_upd}, 32'h1);
        tick(1'b0, 1'b0);
        check("upd_end", {31'd0, user_upd}, 32'h0);

        // Instruction 3 without the optional feature behaves as BYPASS
        load_ir(4'b0011);
        check("ir_three", {28'd0, ir_out}, 32'h3);
        goto_shdr();
        shift_bits(3, 32'b011, dout);
        check("ir3_bypass", dout, 32'b110);
        exit_upd();

        // Pause and resume an IDCODE shift without re-capture
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0); goto_shdr();
        shift_bits(4, 32'h0, dout);
        check("idc_lo", dout, 32'h1);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        shift_bits(28, 32'h0, dout);
        check("idc_resume", dout, 32'h0100_0000);
        exit_upd();

        // Five TMS=1 from inside Shift-IR reach TLR and restore IDCODE
        load_ir(4'b0010);
        goto_shir(); tick(1'b0, 1'b1);
        repeat (5) tick(1'b1, 1'b0);
        check("escape_state", {28'd0, tap_state}, 32'h0);
        check("escape_ir", {28'd0, ir_out}, 32'h1);

        // Asynchronous reset in the middle of a USER shift
        tick(1'b0, 1'b0);
        load_ir(4'b0010);
        goto_shdr(); tick(1'b0, 1'b1); tick(1'b0, 1'b0);
        check("pre_rst_uout", {24'd0, user_out}, 32'h3C);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_state", {28'd0, tap_state}, 32'h0);
        check("arst_uout", {24'd0, user_out}, 32'h0);
        check("arst_ir", {28'd0, ir_out}, 32'h1);
        check("arst_oe", {31'd0, tdo_oe}, 32'h0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        tick(1'b0, 1'b0); goto_shdr();
        shift_bits(8, 32'h0, dout);
        check("post_rst_idc", dout, 32'h01);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
